// File: rtl/ha_bist_pkg.sv
// Shared types and constants for the half-adder self-test controller.
package ha_bist_pkg;

    localparam int unsigned NUM_VEC   = 4;
    localparam int unsigned VEC_W     = 2;
    localparam int unsigned SETTLE_CW = 4;
    localparam int unsigned LOOP_W    = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
    } bist_state_e;

    // True in the states that make up an active run.
    function automatic logic is_busy_state(input bist_state_e st);
        return (st == ST_DRIVE) || (st == ST_SETTLE) || (st == ST_CHECK);
    endfunction

endpackage : ha_bist_pkg

// File: rtl/ha_bist_golden.sv
// Golden half-adder response for a 2-bit vector index {a,b}.
module ha_bist_golden
    import ha_bist_pkg::*;
(
    input  logic [VEC_W-1:0] vec,
    output logic             exp_s_c,
    output logic             exp_c_c
);

    // Reference sum and carry from the vector bits.
    always_comb begin
        exp_s_c = vec[1] ^ vec[0];
        exp_c_c = vec[1] & vec[0];
    end

endmodule : ha_bist_golden

// File: rtl/ha_bist_ctrl.sv
// Self-test sequencer for a half adder: drives all {a,b} vectors, samples s/c
// after a settle delay, and reports error count, per-vector fail map and pass.
// Optional build macro HA_BIST_FAULT_INJ_EN adds an 'inject' input that
// inverts the sampled sum during CHECK to force a mismatch.
module ha_bist_ctrl
    import ha_bist_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned LOOPS         = 1,
    parameter int unsigned ERR_W         = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
`ifdef HA_BIST_FAULT_INJ_EN
    input  logic               inject,
`endif
    output logic               dut_a,
    output logic               dut_b,
    input  logic               dut_s,
    input  logic               dut_c,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [ERR_W-1:0]   err_count,
    output logic [NUM_VEC-1:0] fail_vec
);

    bist_state_e          state, state_nxt;
    logic [VEC_W-1:0]     idx, idx_nxt;
    logic [LOOP_W-1:0]    loop_cnt, loop_cnt_nxt;
    logic [SETTLE_CW-1:0] settle_cnt, settle_cnt_nxt;
    logic                 dut_a_nxt, dut_b_nxt;
    logic                 busy_nxt, done_nxt, pass_nxt;
    logic [ERR_W-1:0]     err_count_nxt;
    logic [NUM_VEC-1:0]   fail_vec_nxt;

    logic                 exp_s, exp_c;
    logic                 obs_s;
    logic                 mismatch;

    ha_bist_golden u_golden (
        .vec     (idx),
        .exp_s_c (exp_s),
        .exp_c_c (exp_c)
    );

    // Sampled sum, optionally inverted to force a mismatch.
`ifdef HA_BIST_FAULT_INJ_EN
    always_comb obs_s = dut_s ^ inject;
`else
    always_comb obs_s = dut_s;
`endif

    // A vector fails once, whichever of s/c disagrees.
    always_comb mismatch = (obs_s != exp_s) || (dut_c != exp_c);

    // State, counters and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            idx        <= '0;
            loop_cnt   <= '0;
            settle_cnt <= '0;
            dut_a      <= 1'b0;
            dut_b      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_vec   <= '0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            loop_cnt   <= loop_cnt_nxt;
            settle_cnt <= settle_cnt_nxt;
            dut_a      <= dut_a_nxt;
            dut_b      <= dut_b_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            pass       <= pass_nxt;
            err_count  <= err_count_nxt;
            fail_vec   <= fail_vec_nxt;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        state_nxt      = state;
        idx_nxt        = idx;
        loop_cnt_nxt   = loop_cnt;
        settle_cnt_nxt = settle_cnt;
        dut_a_nxt      = dut_a;
        dut_b_nxt      = dut_b;
        done_nxt       = done;
        pass_nxt       = pass;
        err_count_nxt  = err_count;
        fail_vec_nxt   = fail_vec;

        unique case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_nxt     = ST_DRIVE;
                    idx_nxt       = '0;
                    loop_cnt_nxt  = '0;
                    err_count_nxt = '0;
                    fail_vec_nxt  = '0;
                    done_nxt      = 1'b0;
                    pass_nxt      = 1'b0;
                end
            end
            ST_DRIVE: begin
                dut_a_nxt      = idx[1];
                dut_b_nxt      = idx[0];
                settle_cnt_nxt = '0;
                state_nxt      = (SETTLE_CYCLES == 0) ? ST_CHECK : ST_SETTLE;
            end
            ST_SETTLE: begin
                if (settle_cnt == SETTLE_CW'(SETTLE_CYCLES - 1)) begin
                    state_nxt = ST_CHECK;
                end else begin
                    settle_cnt_nxt = settle_cnt + SETTLE_CW'(1);
                end
            end
            ST_CHECK: begin
                if (mismatch) begin
                    if (err_count != {ERR_W{1'b1}}) begin
                        err_count_nxt = err_count + ERR_W'(1);
                    end
                    fail_vec_nxt[idx] = 1'b1;
                end
                if (idx != VEC_W'(NUM_VEC - 1)) begin
                    idx_nxt   = idx + VEC_W'(1);
                    state_nxt = ST_DRIVE;
                end else if (loop_cnt < LOOP_W'(LOOPS - 1)) begin
                    idx_nxt      = '0;
                    loop_cnt_nxt = loop_cnt + LOOP_W'(1);
                    state_nxt    = ST_DRIVE;
                end else begin
                    state_nxt = ST_DONE;
                    done_nxt  = 1'b1;
                    pass_nxt  = (err_count_nxt == '0);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        busy_nxt = is_busy_state(state_nxt);
    end

endmodule : ha_bist_ctrl
